// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decoder/lookup/imem bundle for the program-counter sequencer
interface pc_sequencer_if #(
    parameter int D = 12
);
    logic         Start;
    logic         Stall;
    logic         Halt_req;
    logic         Br_abs;
    logic         Br_rel;
    logic [D-1:0] Target;
    logic [D-1:0] Prog_ctr;
    logic         Fetch_en;
    logic         Done;
    logic         Fault;
    logic [D-1:0] Fault_pc;
    logic [15:0]  Br_count;

    // Decoder / lookup side drives controls and observes the sequencer
    modport master (
        output Start, Stall, Halt_req, Br_abs, Br_rel, Target,
        input  Prog_ctr, Fetch_en, Done, Fault, Fault_pc, Br_count
    );

    // Sequencer side
    modport slave (
        input  Start, Stall, Halt_req, Br_abs, Br_rel, Target,
        output Prog_ctr, Fetch_en, Done, Fault, Fault_pc, Br_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with branch, stall, halt and range fault
module pc_sequencer #(
    parameter int D        = 12,
    parameter int PROG_LEN = 1024
) (
    input  logic           Clk,
    input  logic           Reset_n,
    pc_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // One extra bit so PROG_LEN == 2^D is representable and never faults
    localparam logic [D:0] PROG_LEN_W = (D+1)'(PROG_LEN);

    state_t       state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic         done_q, done_d;
    logic         fault_q, fault_d;
    logic [D-1:0] fault_pc_q, fault_pc_d;
    logic [15:0]  br_count_q, br_count_d;

    logic [D-1:0] next_pc;
    logic         out_of_range;
    logic         branch_taken;

    // Candidate next address: absolute beats relative beats sequential
    always_comb begin
        branch_taken = bus.Br_abs | bus.Br_rel;
        if (bus.Br_abs)
            next_pc = bus.Target;
        else if (bus.Br_rel)
            next_pc = pc_q + bus.Target;
        else
            next_pc = pc_q + D'(1);
        out_of_range = ({1'b0, next_pc} >= PROG_LEN_W);
    end

    // State and datapath registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            br_count_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            br_count_q <= br_count_d;
        end
    end

    // Next-state: halt > stall > branch/advance, range check gates the PC update
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        done_d     = done_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        br_count_d = br_count_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    state_d    = S_RUN;
                    pc_d       = '0;
                    br_count_d = '0;
                end
            end
            S_RUN: begin
                if (bus.Halt_req) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                end else if (!bus.Stall) begin
                    if (out_of_range) begin
                        state_d    = S_FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = next_pc;
                    end else begin
                        pc_d = next_pc;
                        if (branch_taken && (br_count_q != 16'hFFFF))
                            br_count_d = br_count_q + 16'd1;
                    end
                end
            end
            S_HALT, S_FAULT: begin
                // Fault_pc deliberately survives a restart for post-mortem
                if (bus.Start) begin
                    state_d    = S_RUN;
                    pc_d       = '0;
                    br_count_d = '0;
                    done_d     = 1'b0;
                    fault_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: fetch enable is combinational on stall, the rest are registers
    always_comb begin
        bus.Fetch_en = (state_q == S_RUN) && !bus.Stall;
        bus.Prog_ctr = pc_q;
        bus.Done     = done_q;
        bus.Fault    = fault_q;
        bus.Fault_pc = fault_pc_q;
        bus.Br_count = br_count_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic Clk;
    logic Reset_n;
    int   tests;
    int   fails;

    pc_sequencer_if #(.D(12)) bus ();

    pc_sequencer #(.D(12), .PROG_LEN(1024)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_ctl();
        bus.Start    = 1'b0;
        bus.Stall    = 1'b0;
        bus.Halt_req = 1'b0;
        bus.Br_abs   = 1'b0;
        bus.Br_rel   = 1'b0;
        bus.Target   = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pc"},    32'(bus.Prog_ctr), 32'd0);
        check({tag, "_fetch"}, 32'(bus.Fetch_en), 32'd0);
        check({tag, "_done"},  32'(bus.Done),     32'd0);
        check({tag, "_fault"}, 32'(bus.Fault),    32'd0);
        check({tag, "_fpc"},   32'(bus.Fault_pc), 32'd0);
        check({tag, "_cnt"},   32'(bus.Br_count), 32'd0);
    endtask

    task automatic do_abs(input logic [11:0] t);
        bus.Br_abs = 1'b1; bus.Target = t;
        tick();
        bus.Br_abs = 1'b0; bus.Target = '0;
    endtask

    task automatic do_rel(input logic [11:0] t);
        bus.Br_rel = 1'b1; bus.Target = t;
        tick();
        bus.Br_rel = 1'b0; bus.Target = '0;
    endtask

    task automatic do_start();
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        Reset_n = 1'b0;
        clear_ctl();
        repeat (2) tick();
        check_reset_vals("reset");
        Reset_n = 1'b1;
        tick();
        check("idle_no_start_fetch", 32'(bus.Fetch_en), 32'd0);

        // Start then free-run
        do_start();
        check("start_pc", 32'(bus.Prog_ctr), 32'd0);
        check("start_fetch", 32'(bus.Fetch_en), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("seq_pc%0d", i), 32'(bus.Prog_ctr), 32'(i));
        end
        check("seq_cnt", 32'(bus.Br_count), 32'd0);

        // Relative branches forward and backward
        repeat (5) tick();
        check("at10", 32'(bus.Prog_ctr), 32'd10);
        do_rel(12'd15);
        check("rel_fwd", 32'(bus.Prog_ctr), 32'd25);
        repeat (35) tick();
        check("at60", 32'(bus.Prog_ctr), 32'd60);
        do_rel(12'hFD7);
        check("rel_back", 32'(bus.Prog_ctr), 32'd19);
        check("rel_cnt", 32'(bus.Br_count), 32'd2);

        // Stall holds PC and blocks the branch until released
        do_abs(12'd7);
        check("abs7", 32'(bus.Prog_ctr), 32'd7);
        bus.Stall = 1'b1; bus.Br_abs = 1'b1; bus.Target = 12'd100;
        #1;
        check("stall_fetch", 32'(bus.Fetch_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_pc%0d", i), 32'(bus.Prog_ctr), 32'd7);
        end
        check("stall_cnt", 32'(bus.Br_count), 32'd3);
        bus.Stall = 1'b0;
        tick();
        bus.Br_abs = 1'b0;
        check("unstall_pc", 32'(bus.Prog_ctr), 32'd100);
        check("unstall_cnt", 32'(bus.Br_count), 32'd4);

        // Out-of-range relative branch
        do_abs(12'd1000);
        check("at1000", 32'(bus.Prog_ctr), 32'd1000);
        do_rel(12'd50);
        check("flt_fault", 32'(bus.Fault), 32'd1);
        check("flt_fpc", 32'(bus.Fault_pc), 32'd1050);
        check("flt_pc", 32'(bus.Prog_ctr), 32'd1000);
        check("flt_fetch", 32'(bus.Fetch_en), 32'd0);
        check("flt_cnt", 32'(bus.Br_count), 32'd5);
        do_abs(12'd5);
        check("flt_sticky", 32'(bus.Prog_ctr), 32'd1000);
        do_start();
        check("restart_fault", 32'(bus.Fault), 32'd0);
        check("restart_pc", 32'(bus.Prog_ctr), 32'd0);
        check("restart_fpc", 32'(bus.Fault_pc), 32'd1050);
        check("restart_cnt", 32'(bus.Br_count), 32'd0);

        // Negative offset wrapping past zero
        repeat (3) tick();
        check("at3", 32'(bus.Prog_ctr), 32'd3);
        do_rel(12'hFF0);
        check("wrap_fault", 32'(bus.Fault), 32'd1);
        check("wrap_fpc", 32'(bus.Fault_pc), 32'hFF3);
        check("wrap_pc", 32'(bus.Prog_ctr), 32'd3);

        // Halt beats a simultaneous branch
        do_start();
        bus.Halt_req = 1'b1; bus.Br_abs = 1'b1; bus.Target = 12'd5;
        tick();
        clear_ctl();
        check("halt_done", 32'(bus.Done), 32'd1);
        check("halt_pc", 32'(bus.Prog_ctr), 32'd0);
        check("halt_cnt", 32'(bus.Br_count), 32'd0);
        check("halt_fetch", 32'(bus.Fetch_en), 32'd0);
        tick();
        check("halt_sticky", 32'(bus.Done), 32'd1);
        do_start();
        check("unhalt_done", 32'(bus.Done), 32'd0);

        // Start ignored in RUN; abs and rel together count once
        tick();
        do_start();
        check("run_start_ign", 32'(bus.Prog_ctr), 32'd2);
        bus.Br_abs = 1'b1; bus.Br_rel = 1'b1; bus.Target = 12'd20;
        tick();
        clear_ctl();
        check("both_pc", 32'(bus.Prog_ctr), 32'd20);
        check("both_cnt", 32'(bus.Br_count), 32'd1);

        // Last legal address, then sequential step off the end
        do_abs(12'd1023);
        check("last_pc", 32'(bus.Prog_ctr), 32'd1023);
        tick();
        check("end_fault", 32'(bus.Fault), 32'd1);
        check("end_fpc", 32'(bus.Fault_pc), 32'd1024);
        check("end_pc", 32'(bus.Prog_ctr), 32'd1023);

        // Asynchronous reset mid-run
        do_start();
        do_abs(12'd40);
        do_abs(12'd80);
        do_abs(12'd120);
        do_abs(12'd160);
        do_abs(12'd200);
        check("pre_rst_pc", 32'(bus.Prog_ctr), 32'd200);
        check("pre_rst_cnt", 32'(bus.Br_count), 32'd5);
        bus.Stall = 1'b1; bus.Br_abs = 1'b1; bus.Target = 12'd300;
        #2;
        Reset_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        clear_ctl();
        tick();
        Reset_n = 1'b1;
        tick();
        tick();
        check("post_rst_idle_pc", 32'(bus.Prog_ctr), 32'd0);
        check("post_rst_idle_fetch", 32'(bus.Fetch_en), 32'd0);
        do_start();
        check("resume_fetch", 32'(bus.Fetch_en), 32'd1);
        tick();
        check("resume_pc", 32'(bus.Prog_ctr), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer that consumes the branch-target lookup output. Each cycle it advances the program counter by one, jumps by a signed relative offset, or loads an absolute address, with stall, halt and out-of-range fault handling. Sits between the instruction decoder (branch/halt controls), the target lookup table (offset/address in) and instruction memory (address out).

## Interface

Parameters:
- D, 12, program counter and target width in bits.
- PROG_LEN, 1024, number of valid instruction addresses. Legal PC range is 0..PROG_LEN-1; PROG_LEN <= 2^D.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse; begins or restarts execution at address 0.
- Stall  input  1  hold PC this cycle.
- Halt_req  input  1  decoder reports the halt instruction at current PC.
- Br_abs  input  1  take an absolute jump to Target.
- Br_rel  input  1  take a relative branch by Target.
- Target  input  D  from lookup table; unsigned address for Br_abs, two's-complement offset for Br_rel.
- Prog_ctr  output  D  current instruction address.
- Fetch_en  output  1  instruction memory read enable.
- Done  output  1  program halted normally.
- Fault  output  1  out-of-range next PC detected.
- Fault_pc  output  D  offending next-address value, captured on fault.
- Br_count  output  16  taken-branch count since last Start, saturating.

## Operation

- States: IDLE, RUN, HALT, FAULT. Reset enters IDLE.
- Reset values: Prog_ctr=0, Fetch_en=0, Done=0, Fault=0, Fault_pc=0, Br_count=0.
- IDLE: Start -> RUN with Prog_ctr=0, Br_count=0. All other inputs ignored.
- RUN, per cycle, priority highest first:
  - Halt_req: -> HALT, Done=1, PC holds.
  - Stall: PC holds, no state change; branch inputs ignored.
  - Br_abs: next=Target.
  - Br_rel: next=(Prog_ctr+Target) mod 2^D (Target sign-interpreted, wrap at D bits).
  - otherwise: next=Prog_ctr+1 mod 2^D.
- Range check on next (RUN, non-halt, non-stall only): next >= PROG_LEN -> FAULT, Fault=1, Fault_pc=next, Prog_ctr holds current value. Otherwise Prog_ctr<=next.
- Br_count increments by 1 on each taken Br_abs or Br_rel that passes the range check; saturates at 0xFFFF.
- Br_abs and Br_rel together: Br_abs wins, counts once.
- Start while in RUN: ignored.
- HALT and FAULT: sticky; Prog_ctr, Fault_pc, Br_count frozen. Start -> RUN with Prog_ctr=0, Br_count=0, Done=0, Fault=0; Fault_pc retains last value.
- Fetch_en = (state==RUN) && !Stall, combinational.
- Reset_n low at any time, including mid-branch or during stall: all state returns to reset values immediately.

## Timing

- Prog_ctr, Done, Fault, Fault_pc, Br_count registered; update on the rising Clk edge after the qualifying inputs are sampled.
- Start sampled in IDLE -> Prog_ctr=0 and Fetch_en=1 from the next cycle.
- Branch latency: control asserted in cycle N -> new Prog_ctr visible in cycle N+1. No delay slots.
- Done/Fault rise in the cycle after Halt_req / offending branch sampled; remain high until Start or reset.
- Target must be stable while Br_abs or Br_rel is high; otherwise don't-care.
- Reset deassertion is synchronized externally; the block requires no idle cycles after reset release.

## Test plan

- Reset, then Start, 5 cycles no control -> Prog_ctr 0,1,2,3,4,5; Fetch_en=1; Br_count=0.
- At PC=10, Br_rel with Target=15 -> PC=25 next cycle; then Br_rel with Target=0xFD7 (-41) at PC=60 -> PC=19; Br_count=2.
- Stall high 3 cycles at PC=7 with Br_abs=1, Target=100 -> PC stays 7, Fetch_en=0, Br_count unchanged; release stall with Br_abs still high -> PC=100.
- PROG_LEN=1024, at PC=1000 Br_rel Target=50 -> Fault=1, Fault_pc=1050, Prog_ctr=1000, Fetch_en=0; Start -> Fault=0, PC=0, Fault_pc still 1050.
- At PC=3, Br_rel Target=0xFF0 (-16) -> wraps to 0xFF3 >= PROG_LEN -> FAULT, Fault_pc=0xFF3; Halt_req with Br_abs in same cycle -> HALT, Done=1, PC holds, no count.
- Reset_n asserted mid-RUN at PC=200 with Br_count=5 -> all outputs to reset values immediately, state IDLE, Start required to resume.
